// File: rtl/ipb_io_bridge_if.sv
// IPbus slave handshake plus per-channel register-IO strobes for ipb_io_bridge.
// The bridge connects through the slave modport; the fabric/IO side uses master.
interface ipb_io_bridge_if #(
    parameter int NCH   = 4,
    parameter int SEL_W = 2
);
    logic             ipb_strobe;
    logic             ipb_write;
    logic [SEL_W-1:0] ipb_sel;
    logic [NCH-1:0]   io_rd_ack;
    logic [NCH-1:0]   io_rd_en;
    logic [NCH-1:0]   io_wr_en;
    logic             io_sync;
    logic             ipb_ack;
    logic             ipb_err;

    modport slave (
        input  ipb_strobe, ipb_write, ipb_sel, io_rd_ack,
        output io_rd_en, io_wr_en, io_sync, ipb_ack, ipb_err
    );

    modport master (
        output ipb_strobe, ipb_write, ipb_sel, io_rd_ack,
        input  io_rd_en, io_wr_en, io_sync, ipb_ack, ipb_err
    );
endinterface

// File: rtl/ipb_io_bridge.sv
// IPbus slave to NCH-channel register-IO bridge: held read enable with settle delay,
// timed write enable, and one-cycle ack/err so the bus never hangs.
module ipb_io_bridge #(
    parameter int NCH          = 4,
    parameter int SEL_W        = 2,
    parameter int READ_DLY     = 2,
    parameter int WR_SETUP     = 1,
    parameter int WR_EN_CYCLES = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic                 clk,
    input  logic                 res_n,
    ipb_io_bridge_if.slave       bus
);

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [3:0] RD_LAST = 4'((READ_DLY > 0) ? READ_DLY - 1 : 0);
    localparam logic [3:0] WS_LAST = 4'((WR_SETUP > 0) ? WR_SETUP - 1 : 0);
    localparam logic [3:0] WE_LAST = 4'((WR_EN_CYCLES > 0) ? WR_EN_CYCLES - 1 : 0);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_START,
        S_RD_WAIT,
        S_RD_DLY,
        S_RD_ACK,
        S_WR_SETUP,
        S_WR_EN,
        S_WR_ACK,
        S_ERR
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [SEL_W-1:0] ch;
    logic [NCH-1:0]   ch_oh;
    logic [3:0]       dcnt;
    logic [TO_W-1:0]  tcnt;
    logic             sel_ok;
    logic             rd_ack_hit;

    always_comb begin
        ch_oh = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_oh[i] = (ch == SEL_W'(i));
        end
    end

    assign sel_ok     = (int'(bus.ipb_sel) < NCH);
    // Acks from channels other than the latched one must not advance the read.
    assign rd_ack_hit = |(bus.io_rd_ack & ch_oh);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Both counters restart on every state change so each state times itself from zero.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            ch   <= '0;
            dcnt <= '0;
            tcnt <= '0;
        end else begin
            if (state == S_IDLE && bus.ipb_strobe) begin
                ch <= bus.ipb_sel;
            end
            dcnt <= (next_state != state) ? 4'd0 : dcnt + 4'd1;
            tcnt <= (next_state != state) ? '0 : tcnt + TO_W'(1);
        end
    end

    always_comb begin
        next_state   = state;
        bus.io_rd_en = '0;
        bus.io_wr_en = '0;
        bus.io_sync  = 1'b1;
        bus.ipb_ack  = 1'b0;
        bus.ipb_err  = 1'b0;
        case (state)
            S_IDLE: begin
                bus.io_sync = 1'b0;
                if (bus.ipb_strobe) begin
                    if (!sel_ok)
                        next_state = S_ERR;
                    else if (!bus.ipb_write)
                        next_state = S_RD_START;
                    else if (WR_SETUP > 0)
                        next_state = S_WR_SETUP;
                    else
                        next_state = S_WR_EN;
                end
            end
            S_RD_START: begin
                bus.io_rd_en = ch_oh;
                next_state   = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                bus.io_rd_en = ch_oh;
                // A late ack in the final timeout cycle still completes the read.
                if (rd_ack_hit)
                    next_state = (READ_DLY > 0) ? S_RD_DLY : S_RD_ACK;
                else if (TIMEOUT != 0 && tcnt == TO_LAST)
                    next_state = S_ERR;
            end
            S_RD_DLY: begin
                bus.io_rd_en = ch_oh;
                if (dcnt == RD_LAST)
                    next_state = S_RD_ACK;
            end
            S_RD_ACK: begin
                bus.io_rd_en = ch_oh;
                bus.ipb_ack  = 1'b1;
                next_state   = S_IDLE;
            end
            S_WR_SETUP: begin
                if (dcnt == WS_LAST)
                    next_state = S_WR_EN;
            end
            S_WR_EN: begin
                bus.io_wr_en = ch_oh;
                if (dcnt == WE_LAST)
                    next_state = S_WR_ACK;
            end
            S_WR_ACK: begin
                bus.ipb_ack = 1'b1;
                next_state  = S_IDLE;
            end
            S_ERR: begin
                bus.ipb_err = 1'b1;
                next_state  = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ipb_io_bridge.sv
// Bench for ipb_io_bridge: two configurations driven from shared stimulus, checked
// cycle by cycle against a timing model derived from the transaction rules.
module tb_ipb_io_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       res_n;
    logic       strobe;
    logic       write;
    logic [1:0] sel;
    logic [3:0] rd_ack;
    logic       dsel;

    ipb_io_bridge_if #(.NCH(4), .SEL_W(2)) if0 ();
    ipb_io_bridge_if #(.NCH(3), .SEL_W(2)) if1 ();

    assign if0.ipb_strobe = strobe && !dsel;
    assign if0.ipb_write  = write;
    assign if0.ipb_sel    = sel;
    assign if0.io_rd_ack  = rd_ack;
    assign if1.ipb_strobe = strobe && dsel;
    assign if1.ipb_write  = write;
    assign if1.ipb_sel    = sel;
    assign if1.io_rd_ack  = rd_ack[2:0];

    ipb_io_bridge #(.NCH(4), .SEL_W(2)) u0 (
        .clk(clk), .res_n(res_n), .bus(if0.slave)
    );

    ipb_io_bridge #(.NCH(3), .SEL_W(2), .READ_DLY(2), .WR_SETUP(0),
                    .WR_EN_CYCLES(3), .TIMEOUT(8)) u1 (
        .clk(clk), .res_n(res_n), .bus(if1.slave)
    );

    // {rd_en[3:0], wr_en[3:0], sync, ack, err}
    logic [10:0] obs0, obs1, obs;
    assign obs0 = {if0.io_rd_en, if0.io_wr_en, if0.io_sync, if0.ipb_ack, if0.ipb_err};
    assign obs1 = {1'b0, if1.io_rd_en, 1'b0, if1.io_wr_en, if1.io_sync, if1.ipb_ack, if1.ipb_err};
    assign obs  = dsel ? obs1 : obs0;

    int checks = 0;
    int errors = 0;

    logic [10:0] obs_log [0:511];
    int last_d;

    bit t_write;
    int t_sel;
    int t_ack;

    function automatic int cfg_nch();  return dsel ? 3 : 4;   endfunction
    function automatic int cfg_rdly(); return 2;              endfunction
    function automatic int cfg_ws();   return dsel ? 0 : 1;   endfunction
    function automatic int cfg_we();   return dsel ? 3 : 1;   endfunction
    function automatic int cfg_to();   return dsel ? 8 : 255; endfunction

    // Only an ack seen while waiting, and not after the timeout window, completes a read.
    function automatic bit ack_valid();
        return (t_ack >= 2) && (cfg_to() == 0 || t_ack <= cfg_to() + 1);
    endfunction

    function automatic int done_cycle();
        if (t_sel >= cfg_nch()) return 1;
        if (t_write) return cfg_ws() + cfg_we() + 1;
        if (ack_valid()) return t_ack + cfg_rdly() + 1;
        return cfg_to() + 2;
    endfunction

    function automatic logic [10:0] model(input int t);
        logic [3:0] oh;
        logic [3:0] rd;
        logic [3:0] wr;
        logic sy, ak, er;
        int d;
        oh = 4'b0001 << t_sel;
        rd = 4'b0; wr = 4'b0; ak = 1'b0; er = 1'b0;
        d  = done_cycle();
        sy = (t >= 1 && t <= d);
        if (t_sel >= cfg_nch()) begin
            er = (t == 1);
        end else if (t_write) begin
            if (t >= cfg_ws() + 1 && t <= cfg_ws() + cfg_we()) wr = oh;
            ak = (t == d);
        end else if (ack_valid()) begin
            if (t <= d) rd = oh;
            ak = (t == d);
        end else begin
            if (t <= d - 1) rd = oh;
            er = (t == d);
        end
        return {rd, wr, sy, ak, er};
    endfunction

    // Called in an IDLE cycle, #1 after the edge; issues the strobe there and logs
    // outputs for cycles 1..done+1, leaving the bench in the following IDLE cycle.
    task automatic run_txn(input bit w, input int s, input int a, input bit noise,
                           input bit hold, input logic [3:0] extra, input int extra_at);
        int d;
        t_write = w; t_sel = s; t_ack = a;
        d = done_cycle();
        last_d = d;
        strobe = 1'b1; write = w; sel = 2'(s); rd_ack = 4'b0;
        for (int t = 1; t <= d + 1; t++) begin
            @(posedge clk); #1;
            strobe = hold && (t <= d);
            if (hold) begin
                write = 1'($urandom);
                sel   = 2'($urandom);
            end
            rd_ack = (t == a) ? (4'b0001 << s) : 4'b0000;
            if (noise) rd_ack = rd_ack | (4'($urandom) & ~(4'b0001 << s));
            if (t == extra_at) rd_ack = rd_ack | extra;
            obs_log[t] = obs;
        end
    endtask

    task automatic test_reset();
        res_n = 1'b0; strobe = 1'b0; write = 1'b0; sel = 2'd0; rd_ack = 4'b0; dsel = 1'b0;
        #1;
        checks++;
        if (obs0 !== 11'b0) begin errors++; $display("FAIL reset_u0 got %b exp %b", obs0, 11'b0); end
        checks++;
        if (obs1 !== 11'b0) begin errors++; $display("FAIL reset_u1 got %b exp %b", obs1, 11'b0); end
        strobe = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs0 !== 11'b0) begin errors++; $display("FAIL reset_strobe_u0 got %b exp %b", obs0, 11'b0); end
        strobe = 1'b0;
        @(negedge clk);
        res_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (obs0 !== 11'b0) begin errors++; $display("FAIL reset_release_u0 got %b exp %b", obs0, 11'b0); end
    endtask

    task automatic test_read();
        dsel = 1'b0;
        run_txn(1'b0, 2, 4, 1'b0, 1'b0, 4'b0, 0);
        for (int t = 1; t <= last_d + 1; t++) begin
            checks++;
            if (obs_log[t] !== model(t)) begin
                errors++; $display("FAIL read_ch2 c%0d got %b exp %b", t, obs_log[t], model(t));
            end
        end
        checks++;
        if (obs_log[7] !== 11'b0100_0000_110) begin
            errors++; $display("FAIL read_ch2_ack_c7 got %b exp %b", obs_log[7], 11'b0100_0000_110);
        end
        checks++;
        if (obs_log[6] !== 11'b0100_0000_100) begin
            errors++; $display("FAIL read_ch2_dly_c6 got %b exp %b", obs_log[6], 11'b0100_0000_100);
        end
    endtask

    task automatic test_write();
        dsel = 1'b0;
        run_txn(1'b1, 1, 0, 1'b0, 1'b0, 4'b0, 0);
        for (int t = 1; t <= last_d + 1; t++) begin
            checks++;
            if (obs_log[t] !== model(t)) begin
                errors++; $display("FAIL write_ch1 c%0d got %b exp %b", t, obs_log[t], model(t));
            end
        end
        checks++;
        if (obs_log[2] !== 11'b0000_0010_100 || obs_log[3] !== 11'b0000_0000_110) begin
            errors++; $display("FAIL write_ch1_fixed got %b/%b exp %b/%b", obs_log[2], obs_log[3],
                               11'b0000_0010_100, 11'b0000_0000_110);
        end
        dsel = 1'b1;
        run_txn(1'b1, 1, 0, 1'b0, 1'b0, 4'b0, 0);
        for (int t = 1; t <= last_d + 1; t++) begin
            checks++;
            if (obs_log[t] !== model(t)) begin
                errors++; $display("FAIL write_nosetup c%0d got %b exp %b", t, obs_log[t], model(t));
            end
        end
        checks++;
        if (obs_log[1] !== 11'b0000_0010_100 || obs_log[4] !== 11'b0000_0000_110) begin
            errors++; $display("FAIL write_nosetup_fixed got %b/%b exp %b/%b", obs_log[1], obs_log[4],
                               11'b0000_0010_100, 11'b0000_0000_110);
        end
    endtask

    task automatic test_timeout();
        dsel = 1'b1;
        run_txn(1'b0, 1, 0, 1'b0, 1'b0, 4'b0, 0);
        for (int t = 1; t <= last_d + 1; t++) begin
            checks++;
            if (obs_log[t] !== model(t)) begin
                errors++; $display("FAIL timeout c%0d got %b exp %b", t, obs_log[t], model(t));
            end
        end
        checks++;
        if (obs_log[10] !== 11'b0000_0000_101 || obs_log[9] !== 11'b0010_0000_100) begin
            errors++; $display("FAIL timeout_fixed got %b/%b exp %b/%b", obs_log[9], obs_log[10],
                               11'b0010_0000_100, 11'b0000_0000_101);
        end
        run_txn(1'b0, 1, 9, 1'b0, 1'b0, 4'b0, 0);
        for (int t = 1; t <= last_d + 1; t++) begin
            checks++;
            if (obs_log[t] !== model(t)) begin
                errors++; $display("FAIL timeout_lastack c%0d got %b exp %b", t, obs_log[t], model(t));
            end
        end
        checks++;
        if (obs_log[12] !== 11'b0010_0000_110 || obs_log[10] !== 11'b0010_0000_100) begin
            errors++; $display("FAIL timeout_lastack_fixed got %b/%b exp %b/%b", obs_log[10], obs_log[12],
                               11'b0010_0000_100, 11'b0010_0000_110);
        end
    endtask

    task automatic test_invalid();
        dsel = 1'b1;
        run_txn(1'b0, 3, 2, 1'b0, 1'b0, 4'b0, 0);
        for (int t = 1; t <= last_d + 1; t++) begin
            checks++;
            if (obs_log[t] !== model(t)) begin
                errors++; $display("FAIL invalid_sel c%0d got %b exp %b", t, obs_log[t], model(t));
            end
        end
        checks++;
        if (obs_log[1] !== 11'b0000_0000_101 || obs_log[2] !== 11'b0) begin
            errors++; $display("FAIL invalid_sel_fixed got %b/%b exp %b/%b", obs_log[1], obs_log[2],
                               11'b0000_0000_101, 11'b0);
        end
    endtask

    task automatic test_wrong_ch();
        dsel = 1'b0;
        run_txn(1'b0, 0, 5, 1'b0, 1'b0, 4'b1000, 3);
        for (int t = 1; t <= last_d + 1; t++) begin
            checks++;
            if (obs_log[t] !== model(t)) begin
                errors++; $display("FAIL wrong_ch c%0d got %b exp %b", t, obs_log[t], model(t));
            end
        end
        checks++;
        if (obs_log[8] !== 11'b0001_0000_110 || obs_log[4] !== 11'b0001_0000_100) begin
            errors++; $display("FAIL wrong_ch_fixed got %b/%b exp %b/%b", obs_log[4], obs_log[8],
                               11'b0001_0000_100, 11'b0001_0000_110);
        end
    endtask

    task automatic test_reset_mid_read();
        dsel = 1'b0;
        t_write = 1'b0; t_sel = 2; t_ack = 4;
        strobe = 1'b1; write = 1'b0; sel = 2'd2; rd_ack = 4'b0;
        for (int t = 1; t <= 5; t++) begin
            @(posedge clk); #1;
            strobe = 1'b0;
            rd_ack = (t == 4) ? 4'b0100 : 4'b0000;
            obs_log[t] = obs;
        end
        for (int t = 1; t <= 5; t++) begin
            checks++;
            if (obs_log[t] !== model(t)) begin
                errors++; $display("FAIL pre_reset c%0d got %b exp %b", t, obs_log[t], model(t));
            end
        end
        #2 res_n = 1'b0;
        #1;
        checks++;
        if (obs0 !== 11'b0) begin errors++; $display("FAIL async_reset got %b exp %b", obs0, 11'b0); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (obs0 !== 11'b0) begin errors++; $display("FAIL held_reset k%0d got %b exp %b", k, obs0, 11'b0); end
        end
        #2 res_n = 1'b1;
        @(posedge clk); #1;
        run_txn(1'b0, 2, 4, 1'b0, 1'b0, 4'b0, 0);
        for (int t = 1; t <= last_d + 1; t++) begin
            checks++;
            if (obs_log[t] !== model(t)) begin
                errors++; $display("FAIL post_reset_read c%0d got %b exp %b", t, obs_log[t], model(t));
            end
        end
        checks++;
        if (obs_log[7] !== 11'b0100_0000_110) begin
            errors++; $display("FAIL post_reset_ack_c7 got %b exp %b", obs_log[7], 11'b0100_0000_110);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 40; n++) begin
            bit w;
            int s;
            int a;
            dsel = 1'($urandom);
            w    = 1'($urandom);
            s    = int'($urandom_range(0, 3));
            a    = dsel ? int'($urandom_range(0, 12)) : int'($urandom_range(1, 12));
            run_txn(w, s, a, 1'($urandom), 1'($urandom), 4'b0, 0);
            for (int t = 1; t <= last_d + 1; t++) begin
                checks++;
                if (obs_log[t] !== model(t)) begin
                    errors++;
                    $display("FAIL random n%0d dut%0d w%0d sel%0d ack_at%0d c%0d got %b exp %b",
                             n, dsel, w, s, a, t, obs_log[t], model(t));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_invalid();
        test_wrong_ch();
        test_reset_mid_read();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
